// File: rtl/decode_pkg.sv
// Shared field positions and packed control-word layout for the decode-stage
// split/pack helper.
package decode_pkg;

  localparam int PACK_W = 42;

  // Instruction field positions (MIPS I/R/J formats overlap on purpose)
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO_I = 11;
  localparam int SA_HI   = 10;
  localparam int SA_LO   = 6;
  localparam int FUN_HI  = 5;
  localparam int FUN_LO  = 0;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int IIDX_HI = 25;
  localparam int IIDX_LO = 0;

  // Packed control-word slices, MSB to LSB
  localparam int AF_HI   = 41;
  localparam int AF_LO   = 38;
  localparam int I_BIT   = 37;
  localparam int AMS_BIT = 36;
  localparam int ST_HI   = 35;
  localparam int ST_LO   = 33;
  localparam int CAD_HI  = 32;
  localparam int CAD_LO  = 28;
  localparam int GPWE_BIT = 27;
  localparam int GPMS_HI = 26;
  localparam int GPMS_LO = 24;
  localparam int BF_HI   = 23;
  localparam int BF_LO   = 20;
  localparam int PCMS_HI = 19;
  localparam int PCMS_LO = 18;
  localparam int SPR_BIT = 17;
  localparam int MWR_BIT = 16;
  localparam int MRD_BIT = 15;
  localparam int PRS_HI  = 14;
  localparam int PRS_LO  = 10;
  localparam int PRT_HI  = 9;
  localparam int PRT_LO  = 5;
  localparam int PRD_HI  = 4;
  localparam int RD_LO   = 0;

  // Struct view of the same layout; member order must match the slices above
  typedef struct packed {
    logic [3:0] af;
    logic       i;
    logic       alu_mux_sel;
    logic [2:0] shift_type;
    logic [4:0] cad;
    logic       gp_we;
    logic [2:0] gp_mux_sel;
    logic [3:0] bf;
    logic [1:0] pc_mux_select;
    logic       spr_mux_sel;
    logic       mem_wren;
    logic       mem_rren;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } ctrl_word_t;

endpackage

// File: rtl/instr_field_split.sv
// Pure wiring that slices a 32-bit MIPS instruction into its standard fields;
// no opcode gating, so overlapping fields are all driven every cycle.
module instr_field_split
  import decode_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [5:0]  opc,
  output logic [5:0]  fun,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [15:0] imm,
  output logic [25:0] iindex
);

  assign opc    = instruction[OPC_HI:OPC_LO];
  assign fun    = instruction[FUN_HI:FUN_LO];
  assign rs     = instruction[RS_HI:RS_LO];
  assign rt     = instruction[RT_HI:RT_LO];
  assign rd     = instruction[RD_HI:RD_LO_I];
  assign sa     = instruction[SA_HI:SA_LO];
  assign imm    = instruction[IMM_HI:IMM_LO];
  assign iindex = instruction[IIDX_HI:IIDX_LO];

endmodule

// File: rtl/decode_split_pack.sv
// Decode-stage helper: splits the instruction, packs decoder controls plus
// rs/rt/rd into a 42-bit word, and registers it with a valid flag.
module decode_split_pack
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [3:0]        af,
  input  logic              i,
  input  logic              alu_mux_sel,
  input  logic [2:0]        shift_type,
  input  logic [4:0]        cad,
  input  logic              gp_we,
  input  logic [2:0]        gp_mux_sel,
  input  logic [3:0]        bf,
  input  logic [1:0]        pc_mux_select,
  input  logic              spr_mux_sel,
  input  logic              mem_wren,
  input  logic              mem_rren,
  output logic [5:0]        opc,
  output logic [5:0]        fun,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        sa,
  output logic [15:0]       imm,
  output logic [25:0]       iindex,
  output logic [PACK_W-1:0] packed_comb,
  output logic [PACK_W-1:0] packed_q,
  output logic              valid_q
);

  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  ctrl_word_t  w_word;
  logic [PACK_W-1:0] r_packed;
  logic              r_valid;

  instr_field_split u_split (
    .instruction (instruction),
    .opc         (opc),
    .fun         (fun),
    .rs          (w_rs),
    .rt          (w_rt),
    .rd          (w_rd),
    .sa          (sa),
    .imm         (imm),
    .iindex      (iindex)
  );

  assign rs = w_rs;
  assign rt = w_rt;
  assign rd = w_rd;

  assign w_word = '{
    af:            af,
    i:             i,
    alu_mux_sel:   alu_mux_sel,
    shift_type:    shift_type,
    cad:           cad,
    gp_we:         gp_we,
    gp_mux_sel:    gp_mux_sel,
    bf:            bf,
    pc_mux_select: pc_mux_select,
    spr_mux_sel:   spr_mux_sel,
    mem_wren:      mem_wren,
    mem_rren:      mem_rren,
    rs:            w_rs,
    rt:            w_rt,
    rd:            w_rd
  };

  assign packed_comb = w_word;

  // A bubble clears valid but leaves the last word in place.
  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_packed <= '0;
      r_valid  <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_packed <= packed_comb;
      end
    end
  end

  assign packed_q = r_packed;
  assign valid_q  = r_valid;

endmodule

// File: tb/tb_decode_split_pack.sv
// Directed self-checking bench for decode_split_pack: field split, packing,
// register latency, stall hold, async reset and walking-one bit placement.
module tb_decode_split_pack;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic        in_valid;
  logic        stall;
  logic [3:0]  af;
  logic        i;
  logic        alu_mux_sel;
  logic [2:0]  shift_type;
  logic [4:0]  cad;
  logic        gp_we;
  logic [2:0]  gp_mux_sel;
  logic [3:0]  bf;
  logic [1:0]  pc_mux_select;
  logic        spr_mux_sel;
  logic        mem_wren;
  logic        mem_rren;
  logic [5:0]  opc;
  logic [5:0]  fun;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [15:0] imm;
  logic [25:0] iindex;
  logic [41:0] packed_comb;
  logic [41:0] packed_q;
  logic        valid_q;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [41:0] WORD_ADD  = 42'h0_4880C_2548;
  localparam logic [41:0] WORD_ADDF = 42'h3C4880C2548;

  decode_split_pack dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruction   (instruction),
    .in_valid      (in_valid),
    .stall         (stall),
    .af            (af),
    .i             (i),
    .alu_mux_sel   (alu_mux_sel),
    .shift_type    (shift_type),
    .cad           (cad),
    .gp_we         (gp_we),
    .gp_mux_sel    (gp_mux_sel),
    .bf            (bf),
    .pc_mux_select (pc_mux_select),
    .spr_mux_sel   (spr_mux_sel),
    .mem_wren      (mem_wren),
    .mem_rren      (mem_rren),
    .opc           (opc),
    .fun           (fun),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .sa            (sa),
    .imm           (imm),
    .iindex        (iindex),
    .packed_comb   (packed_comb),
    .packed_q      (packed_q),
    .valid_q       (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Control vector order: af, i, alu_mux_sel, shift_type, cad, gp_we,
  // gp_mux_sel, bf, pc_mux_select, spr_mux_sel, mem_wren, mem_rren
  task automatic set_ctrl(input logic [26:0] v);
    af            = v[26:23];
    i             = v[22];
    alu_mux_sel   = v[21];
    shift_type    = v[20:18];
    cad           = v[17:13];
    gp_we         = v[12];
    gp_mux_sel    = v[11:9];
    bf            = v[8:5];
    pc_mux_select = v[4:3];
    spr_mux_sel   = v[2];
    mem_wren      = v[1];
    mem_rren      = v[0];
  endtask

  task automatic set_case2();
    instruction   = 32'h012A4020;
    set_ctrl('0);
    shift_type    = 3'b010;
    cad           = 5'd8;
    gp_we         = 1'b1;
    pc_mux_select = 2'b11;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = '0;
    in_valid    = 1'b0;
    stall       = 1'b0;
    set_ctrl('0);
    #2;
    check("reset_packed_q", 64'(packed_q), 64'h0);
    check("reset_valid_q",  64'(valid_q),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Split of lw $10, 4($9)
    instruction = 32'h8D2A0004;
    #1;
    check("lw_opc",    64'(opc),    64'h23);
    check("lw_rs",     64'(rs),     64'd9);
    check("lw_rt",     64'(rt),     64'd10);
    check("lw_imm",    64'(imm),    64'h0004);
    check("lw_rd",     64'(rd),     64'd0);
    check("lw_sa",     64'(sa),     64'd0);
    check("lw_fun",    64'(fun),    64'h04);
    check("lw_iindex", 64'(iindex), 64'h12A0004);

    // Pack of add $8, $9, $10 with its decoder controls
    set_case2();
    #1;
    check("add_rs",  64'(rs),  64'd9);
    check("add_rt",  64'(rt),  64'd10);
    check("add_rd",  64'(rd),  64'd8);
    check("add_fun", 64'(fun), 64'h20);
    check("add_packed_comb", 64'(packed_comb), 64'(WORD_ADD));

    // One-cycle latency, then a bubble
    in_valid = 1'b1;
    tick();
    check("lat_packed_q", 64'(packed_q), 64'(WORD_ADD));
    check("lat_valid_q",  64'(valid_q),  64'h1);
    @(negedge clk);
    in_valid = 1'b0;
    instruction = 32'hFFFFFFFF;
    tick();
    check("bubble_valid_q",  64'(valid_q),  64'h0);
    check("bubble_packed_q", 64'(packed_q), 64'(WORD_ADD));

    // Re-capture, then stall with new inputs for three cycles
    @(negedge clk);
    set_case2();
    in_valid = 1'b1;
    tick();
    check("recap_valid_q", 64'(valid_q), 64'h1);
    @(negedge clk);
    stall = 1'b1;
    af    = 4'hF;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_packed_q", 64'(packed_q), 64'(WORD_ADD));
      check("stall_valid_q",  64'(valid_q),  64'h1);
    end
    check("stall_packed_comb", 64'(packed_comb), 64'(WORD_ADDF));
    @(negedge clk);
    stall = 1'b0;
    tick();
    check("unstall_packed_q", 64'(packed_q), 64'(WORD_ADDF));
    check("unstall_valid_q",  64'(valid_q),  64'h1);

    // Async reset between edges while stalled with a valid word held
    @(negedge clk);
    stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_packed_q", 64'(packed_q), 64'h0);
    check("areset_valid_q",  64'(valid_q),  64'h0);
    tick();
    check("areset_hold_packed_q", 64'(packed_q), 64'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    stall    = 1'b0;
    in_valid = 1'b0;
    tick();
    check("release_packed_q", 64'(packed_q), 64'h0);
    check("release_valid_q",  64'(valid_q),  64'h0);
    @(negedge clk);
    in_valid = 1'b1;
    tick();
    check("post_reset_packed_q", 64'(packed_q), 64'(WORD_ADDF));
    check("post_reset_valid_q",  64'(valid_q),  64'h1);

    // Walking one across every control input bit; rs/rt/rd stay zero
    @(negedge clk);
    in_valid    = 1'b0;
    instruction = '0;
    for (int k = 0; k < 27; k++) begin
      logic [26:0] v;
      logic [41:0] exp_word;
      v        = 27'(1) << k;
      exp_word = 42'(1) << (15 + k);
      set_ctrl(v);
      #1;
      check($sformatf("walk_bit%0d", 15 + k), 64'(packed_comb), 64'(exp_word));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
